// File: rtl/ascon_text_sequencer.sv
// ascon_text_sequencer: steps text blocks through the Ascon datapath; optional abort via ASCON_SEQ_ABORT_EN
module ascon_text_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_sel,
  input  logic [LEN_W-1:0] text_length,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic [4:0]       out_bytes,
  output logic             dp_process_en,
  output logic             dp_mode_sel,
  output logic [LEN_W-1:0] dp_text_length,
  output logic [LEN_W-1:0] dp_text_position,
  output logic [127:0]     dp_data_in,
  input  logic [127:0]     dp_data_out,
  output logic             state_we,
`ifdef ASCON_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, WAIT_IN, PROC, CAPT, OUT, FIN} state_t;
  state_t state, state_nx;
  logic ab, last;
  logic [LEN_W-1:0] remaining;
`ifdef ASCON_SEQ_ABORT_EN
  assign ab = abort && state != IDLE;
`else
  assign ab = 1'b0;
`endif
  assign remaining     = dp_text_length - dp_text_position;
  assign last          = remaining < LEN_W'(16);
  assign busy          = state != IDLE;
  // abort suppresses every strobe of the cycle it arrives in
  assign in_ready      = state == WAIT_IN && !ab;
  assign dp_process_en = state == PROC && !ab;
  assign state_we      = state == CAPT && !ab;
  assign out_valid     = state == OUT && !ab;
  assign done          = state == FIN && !ab;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? WAIT_IN : IDLE;
      WAIT_IN: state_nx = in_valid ? PROC : WAIT_IN;
      PROC:    state_nx = CAPT;
      CAPT:    state_nx = OUT;
      OUT:     state_nx = out_ready ? (out_last ? FIN : WAIT_IN) : OUT;
      default: state_nx = IDLE;
    endcase
    if (ab) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      dp_mode_sel      <= 1'b0;
      dp_text_length   <= '0;
      dp_text_position <= '0;
      dp_data_in       <= '0;
      out_data         <= '0;
      out_last         <= 1'b0;
      out_bytes        <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        dp_mode_sel      <= mode_sel;
        dp_text_length   <= text_length;
        dp_text_position <= '0;
      end
      if (in_valid && in_ready) dp_data_in <= in_data;
      if (state_we) begin
        out_data  <= dp_data_out;
        out_last  <= last;
        out_bytes <= last ? {1'b0, remaining[3:0]} : 5'd16;
      end
      if (out_valid && out_ready && !out_last) dp_text_position <= dp_text_position + LEN_W'(16);
    end
  end
`ifdef ASCON_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) aborted <= 1'b0;
    else aborted <= ab;
  end
`endif
endmodule

// File: tb/tb_ascon_text_sequencer.sv
// tb_ascon_text_sequencer: scoreboard bench for ascon_text_sequencer with a behavioural datapath stand-in
module tb_ascon_text_sequencer;
  logic clk = 0, rst_n = 0, start = 0, mode_sel = 0, in_valid = 0, out_ready = 1;
  logic [31:0] text_length = 0;
  logic [127:0] in_data = 0, dp_data_out = 0;
  logic in_ready, out_valid, out_last, dp_process_en, dp_mode_sel, state_we, busy, done;
  logic [127:0] out_data, dp_data_in;
  logic [4:0] out_bytes;
  logic [31:0] dp_text_length, dp_text_position;
`ifdef ASCON_SEQ_ABORT_EN
  logic abort = 0, aborted;
`endif
  localparam logic [127:0] K = {4{32'hA5C3_0F1E}};
  typedef struct {logic [127:0] d; logic l; logic [4:0] b;} exp_t;
  exp_t expq[$];
  logic [64:0] posq[$];
  int vecs = 0, errs = 0, done_cnt = 0;

  ascon_text_sequencer #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel), .text_length(text_length),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_bytes(out_bytes),
    .dp_process_en(dp_process_en), .dp_mode_sel(dp_mode_sel), .dp_text_length(dp_text_length),
    .dp_text_position(dp_text_position), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .state_we(state_we),
`ifdef ASCON_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dp_process_en) dp_data_out <= dp_data_in ^ K ^ {127'b0, dp_mode_sel};

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [64:0] p;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = expq.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last_bytes", {out_last, out_bytes}, {e.l, e.b});
      end
    end
    if (dp_process_en) begin
      if (posq.size() == 0) chk("unexpected_process", 1, 0);
      else begin
        p = posq.pop_front();
        chk("dp_mode_len_pos", {dp_mode_sel, dp_text_length, dp_text_position}, p);
      end
    end
  end

  function automatic logic [127:0] blk(input int len, input int k);
    return {4{32'(len * 256 + k) ^ 32'h3C5A_9600}};
  endfunction

  task automatic expect_block(input logic m, input int len, input int k);
    int rem = len - 16 * k;
    logic l = rem < 16;
    expq.push_back('{blk(len, k) ^ K ^ {127'b0, m}, l, l ? 5'(rem) : 5'd16});
    posq.push_back({m, 32'(len), 32'(16 * k)});
  endtask

  task automatic send(input logic [127:0] d);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic begin_text(input logic m, input int len);
    @(posedge clk); #1 mode_sel = m; text_length = 32'(len); start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run(input logic m, input int len, input int gap);
    int d0 = done_cnt;
    begin_text(m, len);
    for (int k = 0; k <= len / 16; k++) begin
      expect_block(m, len, k);
      repeat (gap) @(posedge clk);
      #1 send(blk(len, k));
    end
    wait_done();
    @(posedge clk); #1;
    chk("done_count", done_cnt - d0, 1);
    @(negedge clk);
    chk("idle_after", {busy, in_ready, out_valid}, 0);
    chk("queue_drained", expq.size() + posq.size(), 0);
  endtask

  task automatic check_cleared(input string n);
    chk({n, "_ctrl"}, {busy, in_ready, out_valid, done, state_we, dp_process_en, out_last, out_bytes}, 0);
    chk({n, "_data"}, {out_data, dp_data_in}, 0);
    chk({n, "_regs"}, {dp_mode_sel, dp_text_length, dp_text_position}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1;
    run(0, 40, 0);
    run(0, 32, 0);
    run(0, 0, 0);
    fork
      run(1, 17, 3);
      begin
        repeat (4) @(posedge clk);
        #1 start = 1; mode_sel = 0; text_length = 100;
        @(posedge clk); #1 start = 0;
      end
    join
    // latency and output hold under back-pressure
    @(posedge clk); #1 out_ready = 0;
    d0 = done_cnt;
    begin_text(0, 0);
    expect_block(0, 0, 0);
    send(blk(0, 0));
    @(negedge clk); chk("lat_t1", {dp_process_en, state_we, out_valid}, 3'b100);
    @(negedge clk); chk("lat_t2", {dp_process_en, state_we, out_valid}, 3'b010);
    @(negedge clk); chk("lat_t3", {dp_process_en, state_we, out_valid}, 3'b001);
    repeat (5) begin
      @(negedge clk);
      chk("hold", {out_data, out_valid, in_ready, out_last, out_bytes}, {blk(0, 0) ^ K, 1'b1, 1'b0, 1'b1, 5'd0});
    end
    @(posedge clk); #1 out_ready = 1;
    wait_done();
    @(posedge clk); #1 chk("lat_done_count", done_cnt - d0, 1);
    // reset asserted while in CAPT
    begin_text(0, 40);
    expect_block(0, 40, 0);
    send(blk(40, 0));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_we) begin ok = 1; break; end
    end
    if (!ok) chk("capt_timeout", 0, 1);
    d0 = done_cnt;
    rst_n = 0;
    @(negedge clk);
    check_cleared("midreset");
    expq.delete();
    posq.delete();
    rst_n = 1;
    run(0, 5, 0);
    chk("midreset_no_done", done_cnt - d0, 1);
`ifdef ASCON_SEQ_ABORT_EN
    out_ready = 0;
    d0 = done_cnt;
    begin_text(0, 0);
    expect_block(0, 0, 0);
    send(blk(0, 0));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
    #1 abort = 1; out_ready = 1;
    @(negedge clk);
    chk("abort_state", {aborted, busy, out_valid, done}, 4'b1000);
    abort = 0;
    @(negedge clk);
    chk("aborted_pulse", {aborted, busy, done}, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    expq.delete();
    @(posedge clk); #1 abort = 1; start = 1; text_length = 0;
    @(posedge clk); #1 abort = 0; start = 0;
    @(negedge clk);
    chk("abort_idle_start", {busy, in_ready, aborted}, 3'b110);
    expect_block(0, 0, 0);
    send(blk(0, 0));
    wait_done();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
